// File: rtl/fp_pkg.sv
// Shared definitions for the digit-serial field-reduction stages: state
// encodings, default operand geometry and the CLOG2 sizing helper.
`ifndef FP_PKG_CLOG2_DEFINED
`define FP_PKG_CLOG2_DEFINED
`define CLOG2(x) $clog2(x)
`endif

package fp_pkg;

    localparam int unsigned FP_RADIX  = 32;
    localparam int unsigned FP_DIGITS = 14;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_COLLECT  = 3'd1;
    localparam logic [2:0] ST_WAIT_CMP = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_FLUSH    = 3'd4;

endpackage

// File: rtl/fp_serial_sub_stage.sv
// Registered borrow-chain digit subtractor: diff = a - (sub_sel ? b : 0) - borrow.
// FP_REDUCE_BORROW_CHECK_EN exposes the combinational borrow-out of the current digit.
module fp_serial_sub_stage #(
    parameter int unsigned RADIX = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic             last_i,
    input  logic             sub_sel_i,
    input  logic [RADIX-1:0] a_i,
    input  logic [RADIX-1:0] b_i,
    output logic             valid_o,
    output logic             last_o,
    output logic [RADIX-1:0] diff_o
`ifdef FP_REDUCE_BORROW_CHECK_EN
   ,output logic             borrow_nxt_o
`endif
);

    logic             valid_q;
    logic             last_q;
    logic             borrow_q;
    logic [RADIX-1:0] diff_q;
    logic [RADIX:0]   diff_w;

    // Top bit of the widened difference is the borrow into the next digit.
    assign diff_w = {1'b0, a_i}
                  - {1'b0, (sub_sel_i ? b_i : {RADIX{1'b0}})}
                  - (RADIX+1)'(borrow_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
        end else begin
            valid_q <= valid_i;
            last_q  <= valid_i & last_i;
            if (clear_i) begin
                borrow_q <= 1'b0;
            end else if (valid_i) begin
                borrow_q <= diff_w[RADIX];
            end
            if (valid_i) begin
                diff_q <= diff_w[RADIX-1:0];
            end
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign diff_o  = diff_q;
`ifdef FP_REDUCE_BORROW_CHECK_EN
    assign borrow_nxt_o = diff_w[RADIX];
`endif

endmodule

// File: rtl/single_port_mem.sv
// Single-port memory with registered read; contents load from INIT on reset,
// so with we_i tied low it serves as a constant ROM.
module single_port_mem #(
    parameter int unsigned    W    = 32,
    parameter int unsigned    D    = 14,
    parameter int unsigned    AW   = (D > 1) ? `CLOG2(D) : 1,
    parameter logic [W*D-1:0] INIT = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [D];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < D; i++) begin
                mem_q[i] <= INIT[i*W +: W];
            end
            rdata_q <= '0;
        end else if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fp_cond_sub_reduce.sv
// Buffers a digit-serial sum, waits for the compare verdict, then re-streams
// sum - 2p (verdict set) or sum (verdict clear). Option: FP_REDUCE_BORROW_CHECK_EN.
module fp_cond_sub_reduce
    import fp_pkg::*;
#(
    parameter int unsigned              RADIX     = FP_RADIX,
    parameter int unsigned              DIGITS    = FP_DIGITS,
    parameter logic [RADIX*DIGITS-1:0]  C2P_CONST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             digit_in_valid,
    input  logic [RADIX-1:0] digit_in,
    input  logic             cmp_done,
    input  logic             cmp_bigger,
    input  logic             carry_in,
    output logic             digit_out_valid,
    output logic [RADIX-1:0] digit_out,
    output logic             done,
    output logic             busy
`ifdef FP_REDUCE_BORROW_CHECK_EN
   ,output logic             reduce_err
`endif
);

    localparam int unsigned AW = (DIGITS > 1) ? `CLOG2(DIGITS) : 1;
    localparam int unsigned CW = `CLOG2(DIGITS + 1);
    localparam logic [CW-1:0] WR_FULL = CW'(DIGITS);
    localparam logic [CW-1:0] WR_LAST = CW'(DIGITS - 1);
    localparam logic [AW-1:0] RD_LAST = AW'(DIGITS - 1);

    logic [2:0]       state_q,   state_d;
    logic [CW-1:0]    wr_cnt_q,  wr_cnt_d;
    logic [AW-1:0]    rd_cnt_q,  rd_cnt_d;
    logic             sub_sel_q, sub_sel_d;
    logic             got_cmp_q, got_cmp_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_last_q,  rd_last_d;
    logic             clear_borrow;

    logic             cmp_take;
    logic             wr_fire;
    logic             rd_en;
    logic [AW-1:0]    buf_addr;
    logic [RADIX-1:0] buf_rdata;
    logic [RADIX-1:0] rom_rdata;
    logic             sub_valid_in;
    logic             sub_valid_out;
    logic             sub_last_out;

    assign cmp_take = cmp_done && ((state_q == ST_COLLECT) || (state_q == ST_WAIT_CMP));
    assign wr_fire  = digit_in_valid && (state_q == ST_COLLECT) && (wr_cnt_q < WR_FULL);
    assign rd_en    = (state_q == ST_DRAIN);
    assign buf_addr = rd_en ? rd_cnt_q : wr_cnt_q[AW-1:0];

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        sub_sel_d    = sub_sel_q;
        got_cmp_d    = got_cmp_q;
        clear_borrow = 1'b0;
        rd_valid_d   = rd_en && !start;
        rd_last_d    = rd_en && (rd_cnt_q == RD_LAST);

        if (cmp_take) begin
            sub_sel_d = cmp_bigger | carry_in;
            got_cmp_d = 1'b1;
        end

        case (state_q)
            ST_COLLECT: begin
                if (wr_fire) begin
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    if (wr_cnt_q == WR_LAST) begin
                        if (got_cmp_q || cmp_done) begin
                            state_d      = ST_DRAIN;
                            rd_cnt_d     = '0;
                            clear_borrow = 1'b1;
                        end else begin
                            state_d = ST_WAIT_CMP;
                        end
                    end
                end
            end
            ST_WAIT_CMP: begin
                if (cmp_done) begin
                    state_d      = ST_DRAIN;
                    rd_cnt_d     = '0;
                    clear_borrow = 1'b1;
                end
            end
            ST_DRAIN: begin
                rd_cnt_d = rd_cnt_q + AW'(1);
                if (rd_cnt_q == RD_LAST) begin
                    state_d  = ST_FLUSH;
                    rd_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                // Last digit enters the subtractor now; done appears with it next cycle.
                if (rd_valid_q && rd_last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (start) begin
            state_d   = ST_COLLECT;
            wr_cnt_d  = '0;
            got_cmp_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            sub_sel_q  <= 1'b0;
            got_cmp_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            sub_sel_q  <= sub_sel_d;
            got_cmp_q  <= got_cmp_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    single_port_mem #(
        .W    (RADIX),
        .D    (DIGITS),
        .AW   (AW),
        .INIT ('0)
    ) u_sum_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (wr_fire | rd_en),
        .we_i    (wr_fire),
        .addr_i  (buf_addr),
        .wdata_i (digit_in),
        .rdata_o (buf_rdata)
    );

    single_port_mem #(
        .W    (RADIX),
        .D    (DIGITS),
        .AW   (AW),
        .INIT (C2P_CONST)
    ) u_c2p_rom (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (rd_en),
        .we_i    (1'b0),
        .addr_i  (rd_cnt_q),
        .wdata_i ('0),
        .rdata_o (rom_rdata)
    );

    // A start while digits are in flight drops them so the aborted op never signals done.
    assign sub_valid_in = rd_valid_q && !start;

`ifdef FP_REDUCE_BORROW_CHECK_EN
    logic final_borrow;
    logic carry_q;
    logic reduce_err_q;
`endif

    fp_serial_sub_stage #(
        .RADIX (RADIX)
    ) u_sub (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_borrow),
        .valid_i      (sub_valid_in),
        .last_i       (rd_last_q),
        .sub_sel_i    (sub_sel_q),
        .a_i          (buf_rdata),
        .b_i          (rom_rdata),
        .valid_o      (sub_valid_out),
        .last_o       (sub_last_out),
        .diff_o       (digit_out)
`ifdef FP_REDUCE_BORROW_CHECK_EN
       ,.borrow_nxt_o (final_borrow)
`endif
    );

`ifdef FP_REDUCE_BORROW_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q      <= 1'b0;
            reduce_err_q <= 1'b0;
        end else begin
            if (cmp_take) begin
                carry_q <= carry_in;
            end
            if (start) begin
                reduce_err_q <= 1'b0;
            end else if (sub_valid_in && rd_last_q) begin
                reduce_err_q <= sub_sel_q & final_borrow & ~carry_q;
            end
        end
    end

    assign reduce_err = reduce_err_q;
`endif

    assign digit_out_valid = sub_valid_out;
    assign done            = sub_valid_out & sub_last_out;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_cond_sub_reduce.sv
// Scoreboard bench for fp_cond_sub_reduce with RADIX=8, DIGITS=4, 2p=0x12345678.
module tb_fp_cond_sub_reduce;

    localparam int unsigned R = 8;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         digit_in_valid = 1'b0;
    logic [R-1:0] digit_in = '0;
    logic         cmp_done = 1'b0;
    logic         cmp_bigger = 1'b0;
    logic         carry_in = 1'b0;
    logic         digit_out_valid;
    logic [R-1:0] digit_out;
    logic         done;
    logic         busy;
`ifdef FP_REDUCE_BORROW_CHECK_EN
    logic         reduce_err;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic [R-1:0] d;
        logic         last;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    fp_cond_sub_reduce #(
        .RADIX     (R),
        .DIGITS    (D),
        .C2P_CONST (32'h1234_5678)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .digit_in_valid  (digit_in_valid),
        .digit_in        (digit_in),
        .cmp_done        (cmp_done),
        .cmp_bigger      (cmp_bigger),
        .carry_in        (carry_in),
        .digit_out_valid (digit_out_valid),
        .digit_out       (digit_out),
        .done            (done),
        .busy            (busy)
`ifdef FP_REDUCE_BORROW_CHECK_EN
       ,.reduce_err      (reduce_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every presented digit is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (digit_out_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_digit: got %0h expected no output (cycle %0d)", digit_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("digit", digit_out, mon_e.d);
                chk("done", done, mon_e.last);
                chk("latency", cyc, mon_e.cyc);
            end
        end else if (done) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_without_digit: got done=1 expected 0 (cycle %0d)", cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input logic [31:0] sum, input logic [3:0] cmp_m,
                           input logic [3:0] big_m, input logic cy, output int c_last);
        start = 1'b1;
        tick();
        start = 1'b0;
        c_last = 0;
        for (int i = 0; i < 4; i++) begin
            digit_in_valid = 1'b1;
            digit_in       = sum[8*i +: 8];
            cmp_done       = cmp_m[i];
            cmp_bigger     = big_m[i];
            carry_in       = cy;
            c_last         = cyc;
            tick();
        end
        digit_in_valid = 1'b0;
        digit_in       = '0;
        cmp_done       = 1'b0;
        cmp_bigger     = 1'b0;
        carry_in       = 1'b0;
    endtask

    task automatic expect_val(input logic [31:0] v, input int c0);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.d    = v[8*i +: 8];
            e.last = (i == 3);
            e.cyc  = c0 + i;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_drain"}, sb.size(), 0);
        sb.delete();
        tick();
        tick();
        chk({name, "_idle"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int c2;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", digit_out_valid, 0);
        chk("rst_digit", digit_out, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
`ifdef FP_REDUCE_BORROW_CHECK_EN
        chk("rst_err", reduce_err, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Case 1: verdict clear, sum passes through.
        collect(32'h0000_0010, 4'b1000, 4'b0000, 1'b0, c);
        expect_val(32'h0000_0010, c + 3);
        drain("c1");

        // Case 2: sum just above 2p.
        collect(32'h1234_5679, 4'b1000, 4'b1000, 1'b0, c);
        expect_val(32'h0000_0001, c + 3);
        drain("c2");

        // Case 3: carry-out set, 2^32 - 2p.
        collect(32'h0000_0000, 4'b1000, 4'b0000, 1'b1, c);
        expect_val(32'hEDCB_A988, c + 3);
        drain("c3");
`ifdef FP_REDUCE_BORROW_CHECK_EN
        chk("c3_err", reduce_err, 0);
`endif

        // Case 6: reset asserted mid-collect.
        start = 1'b1;
        tick();
        start = 1'b0;
        digit_in_valid = 1'b1;
        digit_in = 8'h10;
        tick();
        digit_in = 8'h00;
        tick();
        digit_in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("c6_valid", digit_out_valid, 0);
        chk("c6_digit", digit_out, 0);
        chk("c6_done", done, 0);
        chk("c6_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        collect(32'h0000_0010, 4'b1000, 4'b0000, 1'b0, c);
        expect_val(32'h0000_0010, c + 3);
        drain("c6_rerun");

        // Case 4a: early verdict, then overwritten; equality passes through.
        collect(32'h1234_5678, 4'b0011, 4'b0001, 1'b0, c);
        expect_val(32'h1234_5678, c + 3);
        drain("c4a");

        // Case 4b: late verdict; stray digits while waiting are ignored.
        collect(32'h8000_0000, 4'b0000, 4'b0000, 1'b0, c);
        while (cyc < c + 5) begin
            digit_in_valid = 1'b1;
            digit_in = 8'hFF;
            chk("c4b_busy", busy, 1);
            tick();
        end
        digit_in_valid = 1'b0;
        digit_in = '0;
        cmp_done = 1'b1;
        cmp_bigger = 1'b1;
        expect_val(32'h6DCB_A988, cyc + 3);
        tick();
        cmp_done = 1'b0;
        cmp_bigger = 1'b0;
        drain("c4b");

        // Case 5: restart during drain, aborted op produces nothing.
        collect(32'h0000_0010, 4'b1000, 4'b0000, 1'b0, c);
        tick();
        collect(32'h1234_5679, 4'b1000, 4'b1000, 1'b0, c2);
        expect_val(32'h0000_0001, c2 + 3);
        drain("c5");

`ifdef FP_REDUCE_BORROW_CHECK_EN
        // Inconsistent verdict: flagged bigger while sum < 2p and no carry.
        collect(32'h0000_0010, 4'b1000, 4'b1000, 1'b0, c);
        expect_val(32'hEDCB_A998, c + 3);
        drain("err");
        chk("err_set", reduce_err, 1);
        tick();
        tick();
        chk("err_hold", reduce_err, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_clear", reduce_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
